bp_btb_redirect: RTL

Fetch-stage branch target buffer and misprediction-redirect unit for the branch-prediction path. Combines the direction bit from the global-history predictor with a direct-mapped target cache to produce the next fetch PC. Carries the prediction down the F→D→E→M pipeline and, when the branch resolves in M, returns the predicted direction to the global predictor, raises a redirect, and trains the target cache.

---
 rtl/bp_btb_redirect_if.sv | 33 +++
 rtl/bp_btb_redirect.sv | 118 +++++++++++
 2 files changed

// File: rtl/bp_btb_redirect_if.sv
// Fetch/resolve signal bundle for bp_btb_redirect.
// master drives the pipeline inputs; slave is the BTB/redirect unit.
interface bp_btb_redirect_if;
    logic [31:0] pcF;
    logic        pcsrcPF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic        branchM;
    logic        pcsrcM;
    logic [31:0] pc_branchM;
    logic [31:0] targetM;
    logic        hitF;
    logic        pred_takenF;
    logic [31:0] pc_nextF;
    logic        pcsrcPM;
    logic        mispredictM;
    logic [31:0] redirect_pcM;

    modport master (
        output pcF, pcsrcPF, stallD, stallE, flushD, flushE, flushM,
               branchM, pcsrcM, pc_branchM, targetM,
        input  hitF, pred_takenF, pc_nextF, pcsrcPM, mispredictM, redirect_pcM
    );

    modport slave (
        input  pcF, pcsrcPF, stallD, stallE, flushD, flushE, flushM,
               branchM, pcsrcM, pc_branchM, targetM,
        output hitF, pred_takenF, pc_nextF, pcsrcPM, mispredictM, redirect_pcM
    );
endinterface

// File: rtl/bp_btb_redirect.sv
// Direct-mapped BTB with F->D->E->M prediction pipeline and M-stage redirect.
// Optional macro BTB_BYPASS_EN forwards a same-cycle training write to the F lookup.
module bp_btb_redirect #(
    parameter int BTB_DEPTH = 6,
    parameter int TAG_WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    bp_btb_redirect_if.slave bus
);
    localparam int ENTRIES = 1 << BTB_DEPTH;

    typedef logic [BTB_DEPTH-1:0] idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_t;

    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    // Key is the delay-slot PC, so a branch trains pc_branchM+4.
    logic train_en;
    idx_t train_idx;
    tag_t train_tag;
    idx_t fetch_idx;
    tag_t fetch_tag;

    assign train_en  = bus.branchM & bus.pcsrcM & ~rst;
    assign train_idx = idx_t'((bus.pc_branchM + 32'd4) >> 2);
    assign train_tag = tag_t'((bus.pc_branchM + 32'd4) >> (BTB_DEPTH + 2));
    assign fetch_idx = idx_t'(bus.pcF >> 2);
    assign fetch_tag = tag_t'(bus.pcF >> (BTB_DEPTH + 2));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (train_en) begin
            valid_q[train_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target RAM is deliberately not reset; valid_q alone decides whether an entry can hit.
    always_ff @(posedge clk) begin
        if (train_en) begin
            tag_mem[train_idx]    <= train_tag;
            target_mem[train_idx] <= bus.targetM;
        end
    end

    logic        rd_valid;
    tag_t        rd_tag;
    logic [31:0] rd_target;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_valid  = valid_q[fetch_idx];
        rd_tag    = tag_mem[fetch_idx];
        rd_target = target_mem[fetch_idx];
`ifdef BTB_BYPASS_EN
        if (train_en && (train_idx == fetch_idx)) begin
            rd_valid  = 1'b1;
            rd_tag    = train_tag;
            rd_target = bus.targetM;
        end
`endif
    end

    assign bus.hitF        = rd_valid & (rd_tag == fetch_tag);
    assign bus.pred_takenF = bus.hitF & bus.pcsrcPF;
    assign bus.pc_nextF    = bus.pred_takenF ? rd_target : (bus.pcF + 32'd4);

    pred_t pred_f, pred_d, pred_e, pred_m;

    assign pred_f = '{pred_taken: bus.pred_takenF, pred_target: rd_target};

    // Flush wins over stall at each stage.
    always_ff @(posedge clk) begin
        if (rst || bus.flushD) begin
            pred_d <= '0;
        end else if (!bus.stallD) begin
            pred_d <= pred_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flushE) begin
            pred_e <= '0;
        end else if (!bus.stallE) begin
            pred_e <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flushM) begin
            pred_m <= '0;
        end else begin
            pred_m <= pred_e;
        end
    end

    assign bus.pcsrcPM = pred_m.pred_taken;

    always_comb begin
        bus.mispredictM  = 1'b0;
        bus.redirect_pcM = 32'd0;
        if (bus.branchM) begin
            bus.mispredictM  = (pred_m.pred_taken != bus.pcsrcM)
                             | (bus.pcsrcM & pred_m.pred_taken
                                & (pred_m.pred_target != bus.targetM));
            bus.redirect_pcM = bus.pcsrcM ? bus.targetM : (bus.pc_branchM + 32'd8);
        end
    end
endmodule
